// File: rtl/traffic_light_ctrl.sv
// traffic_light_ctrl
//   Two-road intersection sequencer. A prescaler turns the system clock into
//   a one-second tick. The phase timer steps both roads through green, yellow
//   and all-red phases in the order AR2 -> MG -> MY -> AR1 -> SG -> SY -> AR2.
//   A latched pedestrian request shortens main green to MIN_GREEN ticks. The
//   next side-green phase then grants the walk lamp. The remaining phase time
//   is exported for a countdown display.
//
// Ports
//   clk      in   system clock, rising edge
//   rst      in   synchronous reset, active-high
//   en       in   run enable; 0 freezes prescaler and phase timer
//   ped_req  in   pedestrian request, sampled every cycle
//   main_r/main_y/main_g  out  main road lamps
//   side_r/side_y/side_g  out  side road lamps
//   walk     out  pedestrian walk lamp (only during side green)
//   remain   out  ticks remaining in the current phase (dur..1)
//   phase    out  0=MG 1=MY 2=AR1 3=SG 4=SY 5=AR2
module traffic_light_ctrl #(
  parameter int unsigned TICK_DIV    = 50000000,
  parameter int unsigned GREEN_TIME  = 15,
  parameter int unsigned YELLOW_TIME = 5,
  parameter int unsigned ALLRED_TIME = 2,
  parameter int unsigned MIN_GREEN   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  output logic       main_r,
  output logic       main_y,
  output logic       main_g,
  output logic       side_r,
  output logic       side_y,
  output logic       side_g,
  output logic       walk,
  output logic [7:0] remain,
  output logic [2:0] phase
);

  typedef enum logic [2:0] {
    S_MG  = 3'd0,
    S_MY  = 3'd1,
    S_AR1 = 3'd2,
    S_SG  = 3'd3,
    S_SY  = 3'd4,
    S_AR2 = 3'd5
  } state_t;

  localparam logic [31:0] PRE_LAST    = 32'(TICK_DIV - 1);
  localparam logic [7:0]  GREEN_D     = 8'(GREEN_TIME);
  localparam logic [7:0]  YELLOW_D    = 8'(YELLOW_TIME);
  localparam logic [7:0]  ALLRED_D    = 8'(ALLRED_TIME);
  localparam logic [7:0]  MG_MIN_LAST = 8'(MIN_GREEN - 1);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pre_cnt;
  logic [7:0]  tcnt;
  logic        ped_pending;

  logic        tick;
  logic        early_end;
  logic        phase_end;
  logic [7:0]  dur;
  logic [7:0]  dur_nxt;
  logic [5:0]  lamps_nxt;

  // Phase length in ticks for a given state.
  function automatic logic [7:0] dur_of(input state_t s);
    case (s)
      S_MG, S_SG: dur_of = GREEN_D;
      S_MY, S_SY: dur_of = YELLOW_D;
      default:    dur_of = ALLRED_D;
    endcase
  endfunction

  // The fixed cyclic successor of each state.
  function automatic state_t next_of(input state_t s);
    case (s)
      S_AR2:   next_of = S_MG;
      S_MG:    next_of = S_MY;
      S_MY:    next_of = S_AR1;
      S_AR1:   next_of = S_SG;
      S_SG:    next_of = S_SY;
      default: next_of = S_AR2;
    endcase
  endfunction

  // Lamp pattern {main_r, main_y, main_g, side_r, side_y, side_g}.
  function automatic logic [5:0] lamps_of(input state_t s);
    case (s)
      S_MG:    lamps_of = 6'b001_100;
      S_MY:    lamps_of = 6'b010_100;
      S_SG:    lamps_of = 6'b100_001;
      S_SY:    lamps_of = 6'b100_010;
      default: lamps_of = 6'b100_100;
    endcase
  endfunction

  always_comb begin
    tick      = en && (pre_cnt == PRE_LAST);
    dur       = dur_of(state);
    // A pending pedestrian cuts main green once MIN_GREEN ticks have elapsed.
    early_end = (state == S_MG) && ped_pending && (tcnt >= MG_MIN_LAST);
    phase_end = tick && ((tcnt == dur - 8'd1) || early_end);
    state_nxt = next_of(state);
    dur_nxt   = dur_of(state_nxt);
    lamps_nxt = lamps_of(state_nxt);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_AR2;
      pre_cnt     <= '0;
      tcnt        <= '0;
      ped_pending <= 1'b0;
      walk        <= 1'b0;
      {main_r, main_y, main_g, side_r, side_y, side_g} <= lamps_of(S_AR2);
      phase       <= 3'(S_AR2);
      remain      <= ALLRED_D;
    end else begin
      if (en) begin
        pre_cnt <= tick ? '0 : pre_cnt + 32'd1;
      end

      ped_pending <= ped_pending | ped_req;

      if (phase_end) begin
        state  <= state_nxt;
        tcnt   <= '0;
        remain <= dur_nxt;
        phase  <= 3'(state_nxt);
        {main_r, main_y, main_g, side_r, side_y, side_g} <= lamps_nxt;
        // Entering side green consumes the pending request. A request in
        // this same cycle is kept pending so it is not lost.
        if (state_nxt == S_SG) begin
          walk        <= ped_pending;
          ped_pending <= ped_req;
        end
        if (state == S_SG) begin
          walk <= 1'b0;
        end
      end else if (tick) begin
        tcnt   <= tcnt + 8'd1;
        remain <= dur - (tcnt + 8'd1);
      end
    end
  end

endmodule

// File: doc/traffic_light_ctrl.md
Name: traffic_light_ctrl

Overview:
Two-road intersection sequencer for the traffic light design. It derives a one-second tick from the system clock and steps the main road and side road lights through green, yellow and all-red phases. It latches a pedestrian request, which shortens main green and grants a walk signal during side green. It also exports the remaining phase time for the countdown display.

Parameters:
TICK_DIV, 50000000, clock cycles per tick; legal range 1..2^32-1.
GREEN_TIME, 15, green phase length in ticks (both roads); 1..255.
YELLOW_TIME, 5, yellow phase length in ticks; 1..255.
ALLRED_TIME, 2, all-red clearance length in ticks; 1..255.
MIN_GREEN, 5, minimum main green in ticks when a pedestrian request is pending; 1..GREEN_TIME.

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
en  in  1  run enable; 0 freezes prescaler and phase timer
ped_req  in  1  pedestrian request, any-length pulse, sampled every cycle
main_r / main_y / main_g  out  1 each  main road lights
side_r / side_y / side_g  out  1 each  side road lights
walk  out  1  pedestrian walk lamp
remain  out  8  ticks remaining in current phase
phase  out  3  0=MG, 1=MY, 2=AR1, 3=SG, 4=SY, 5=AR2

Behaviour:
- All outputs are decoded from registers and change only on the clock edge of a state/counter update.
- Reset values:
  - state AR2, prescaler 0, tcnt 0, ped_pending 0, walk 0.
  - main_r=1, side_r=1, all other lights 0, phase=5, remain=ALLRED_TIME.
- Prescaler:
  - pre_cnt counts 0..TICK_DIV-1 only while en=1.
  - tick=1 in the cycle pre_cnt==TICK_DIV-1 and en=1; pre_cnt wraps to 0 in that cycle.
  - With TICK_DIV=1, tick=en.
- Phase timer:
  - tcnt (8 bit) increments on tick.
  - On the tick where tcnt==dur-1, the state advances and tcnt is cleared.
  - Each phase therefore lasts exactly dur ticks, i.e. dur*TICK_DIV enabled cycles.
  - remain = dur - tcnt, so it counts dur..1.
- Durations:
  - MG and SG: GREEN_TIME.
  - MY and SY: YELLOW_TIME.
  - AR1 and AR2: ALLRED_TIME.
- State sequence: AR2 -> MG -> MY -> AR1 -> SG -> SY -> AR2; no other transitions.
- Lights per state:
  - MG: main_g, side_r.
  - MY: main_y, side_r.
  - AR1, AR2: main_r, side_r.
  - SG: main_r, side_g.
  - SY: main_r, side_y.
  - main_g and side_g are never 1 together.
- Early termination of MG:
  - MG also ends on a tick where ped_pending=1 and tcnt>=MIN_GREEN-1.
  - remain in MG still reports GREEN_TIME-tcnt and drops to MY without reaching 1.
- Pedestrian handling:
  - ped_pending sets on any cycle with ped_req=1, including when en=0 and in any state.
  - On the edge entering SG: walk<=ped_pending and ped_pending<=ped_req (a request in that same cycle remains pending for the next cycle).
  - walk clears on the edge leaving SG.
  - A request arriving during SG does not raise walk; it is served in the next cycle.
- en=0: pre_cnt, tcnt, state, walk and remain hold; lights unchanged; ped_req still latched.
- Reset mid-operation: all registers return to reset values on the next edge, regardless of en or tick; a pending request is discarded.
- Widths: tcnt compare is 8 bit; pre_cnt is 32 bit. Parameters outside their legal ranges are unsupported.

Test Plan:
- TICK_DIV=4, defaults, en=1, no ped_req, release rst -> phase 5 for 8 cycles, then 0 (60), 1 (20), 2 (8), 3 (60), 4 (20), 5 (8), 0; walk stays 0; main_g & side_g is never 1.
- Same config, ped_req 1-cycle pulse at MG tick 2 -> MG lasts 5 ticks (20 cycles), remain goes 15,14,13,12,11 then MY shows 5; walk=1 for all 60 SG cycles; ped_pending=0 after SG entry.
- ped_req pulse during SG -> walk unchanged in that SG; following MG lasts 5 ticks; walk=1 in the next SG.
- en=0 for 30 cycles mid-MY with remain=3 -> phase=1, remain=3, lights frozen; after en=1, MY completes with exactly 5 ticks in total.
- rst=1 for one cycle during SG with walk=1 and a pending request -> next edge: phase=5, remain=2, main_r=side_r=1, walk=0; no early MG termination afterwards.
- TICK_DIV=1, GREEN_TIME=1, YELLOW_TIME=1, ALLRED_TIME=1 -> phase changes every enabled cycle in order 5,0,1,2,3,4,5; remain constant at 1.
